// File: rtl/conv_filter_scheduler.sv
// Sequences the 3x3 convolution engine over every kernel for one image and
// packs each 26x26 result stream into a flat feature-map buffer.
module conv_filter_scheduler #(
  parameter int NUM_FILTERS = 4,
  parameter int OUT_PIXELS  = 676,
  parameter int GAP_CYCLES  = 5,
  parameter int FM_ADDR_W   = 12,
  parameter int TIMEOUT     = 4095,
  localparam int FSEL_W     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic                 o_conv_start,
  output logic [FSEL_W-1:0]    o_conv_filter_select,
  input  logic                 i_conv_valid,
  input  logic [7:0]           i_conv_data,
  input  logic                 i_conv_done,
  output logic                 o_fm_we,
  output logic [FM_ADDR_W-1:0] o_fm_addr,
  output logic [7:0]           o_fm_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err_count,
  output logic                 o_err_timeout
);

  localparam int PIX_W  = $clog2(OUT_PIXELS + 1);
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [PIX_W-1:0]     PIX_FULL    = PIX_W'(OUT_PIXELS);
  localparam logic [WDOG_W-1:0]    WDOG_LIMIT  = WDOG_W'(TIMEOUT);
  localparam logic [GAP_W-1:0]     GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
  localparam logic [FSEL_W-1:0]    LAST_FILTER = FSEL_W'(NUM_FILTERS - 1);
  localparam logic [FM_ADDR_W-1:0] BASE_STEP   = FM_ADDR_W'(OUT_PIXELS);

  logic [2:0]           r_state;
  logic [FSEL_W-1:0]    r_filter_idx;
  logic [PIX_W-1:0]     r_pix_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [WDOG_W-1:0]    r_wdog;
  logic                 r_done_q;
  logic [FM_ADDR_W-1:0] r_base;

  logic                 w_done_rise;
  logic                 w_accept;
  logic [PIX_W-1:0]     w_pix_after;
  logic [WDOG_W-1:0]    w_wdog_inc;
  logic [2:0]           w_state_fsm;
  logic [2:0]           w_state_nxt;
  logic [FSEL_W-1:0]    w_filter_idx_nxt;
  logic [PIX_W-1:0]     w_pix_cnt_nxt;
  logic [GAP_W-1:0]     w_gap_cnt_nxt;
  logic [WDOG_W-1:0]    w_wdog_nxt;
  logic [FM_ADDR_W-1:0] w_base_nxt;
  logic                 w_set_err_count;
  logic                 w_set_err_tmo;
  logic                 w_clr_err;

  // Next-state, counter and error-event decode; abort overrides every transition.
  always_comb begin
    w_done_rise = i_conv_done & ~r_done_q;
    w_accept    = (r_state == S_RUN) && i_conv_valid && (r_pix_cnt < PIX_FULL);
    if (w_accept) begin
      w_pix_after = r_pix_cnt + PIX_W'(1);
    end else begin
      w_pix_after = r_pix_cnt;
    end
    w_wdog_inc = r_wdog + WDOG_W'(1);

    w_state_fsm      = r_state;
    w_filter_idx_nxt = r_filter_idx;
    w_pix_cnt_nxt    = w_pix_after;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_wdog_nxt       = r_wdog;
    w_base_nxt       = r_base;
    w_set_err_count  = 1'b0;
    w_set_err_tmo    = 1'b0;
    w_clr_err        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_fsm      = S_LAUNCH;
          w_clr_err        = 1'b1;
          w_filter_idx_nxt = '0;
          w_base_nxt       = '0;
        end else begin
          w_state_fsm      = S_IDLE;
        end
      end
      S_LAUNCH: begin
        w_state_fsm   = S_RUN;
        w_pix_cnt_nxt = '0;
        w_wdog_nxt    = '0;
      end
      S_RUN: begin
        // A beat coinciding with the done edge is counted before the length check.
        w_set_err_count = (i_conv_valid && !w_accept) ||
                          (w_done_rise && (w_pix_after != PIX_FULL));
        if (w_done_rise) begin
          w_state_fsm   = S_GAP;
          w_gap_cnt_nxt = '0;
          w_wdog_nxt    = '0;
        end else if (i_conv_valid) begin
          w_wdog_nxt    = '0;
        end else if (w_wdog_inc == WDOG_LIMIT) begin
          w_set_err_tmo = 1'b1;
          w_state_fsm   = S_FINISH;
          w_wdog_nxt    = w_wdog_inc;
        end else begin
          w_wdog_nxt    = w_wdog_inc;
        end
      end
      S_GAP: begin
        w_set_err_count = i_conv_valid;
        if (r_gap_cnt == GAP_LAST) begin
          if (r_filter_idx == LAST_FILTER) begin
            w_state_fsm      = S_FINISH;
          end else begin
            w_state_fsm      = S_LAUNCH;
            w_filter_idx_nxt = r_filter_idx + FSEL_W'(1);
            w_base_nxt       = r_base + BASE_STEP;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      S_FINISH: begin
        w_state_fsm = S_IDLE;
      end
      default: begin
        w_state_fsm = S_IDLE;
      end
    endcase

    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = w_state_fsm;
    end
  end

  // State, counters and registered outputs; outputs follow the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state              <= S_IDLE;
      r_filter_idx         <= '0;
      r_pix_cnt            <= '0;
      r_gap_cnt            <= '0;
      r_wdog               <= '0;
      r_done_q             <= 1'b0;
      r_base               <= '0;
      o_conv_start         <= 1'b0;
      o_conv_filter_select <= '0;
      o_fm_we              <= 1'b0;
      o_fm_addr            <= '0;
      o_fm_wdata           <= 8'd0;
      o_busy               <= 1'b0;
      o_done               <= 1'b0;
      o_err_count          <= 1'b0;
      o_err_timeout        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_filter_idx <= w_filter_idx_nxt;
      r_pix_cnt    <= w_pix_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_wdog       <= w_wdog_nxt;
      r_done_q     <= i_conv_done;
      r_base       <= w_base_nxt;

      // A beat captured in an abort cycle still lands in the buffer.
      o_fm_we <= w_accept;
      if (w_accept) begin
        o_fm_addr  <= r_base + FM_ADDR_W'(r_pix_cnt);
        o_fm_wdata <= i_conv_data;
      end

      o_conv_start <= (w_state_nxt == S_LAUNCH);
      if (w_state_nxt == S_LAUNCH) begin
        o_conv_filter_select <= w_filter_idx_nxt;
      end
      o_busy <= (w_state_nxt != S_IDLE);
      o_done <= (w_state_nxt == S_FINISH);

      if (w_clr_err) begin
        o_err_count   <= 1'b0;
        o_err_timeout <= 1'b0;
      end else begin
        if (w_set_err_count) begin
          o_err_count <= 1'b1;
        end
        if (w_set_err_tmo) begin
          o_err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Randomised engine model driving conv_filter_scheduler; expected writes,
// launches and error flags come from a filter-by-filter reference model.
module tb_conv_filter_scheduler;

  localparam int NF  = 4;
  localparam int OUT = 676;
  localparam int TMO = 4095;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        conv_start;
  logic [1:0]  conv_sel;
  logic        conv_valid;
  logic [7:0]  conv_data;
  logic        conv_done;
  logic        fm_we;
  logic [11:0] fm_addr;
  logic [7:0]  fm_wdata;
  logic        busy;
  logic        done;
  logic        err_count;
  logic        err_timeout;

  conv_filter_scheduler dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_start              (start),
    .i_abort              (abort),
    .o_conv_start         (conv_start),
    .o_conv_filter_select (conv_sel),
    .i_conv_valid         (conv_valid),
    .i_conv_data          (conv_data),
    .i_conv_done          (conv_done),
    .o_fm_we              (fm_we),
    .o_fm_addr            (fm_addr),
    .o_fm_wdata           (fm_wdata),
    .o_busy               (busy),
    .o_done               (done),
    .o_err_count          (err_count),
    .o_err_timeout        (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;
  int last_cyc = 0;
  int done_cnt = 0;
  int done_base = 0;

  logic [19:0] expq[$];
  logic [19:0] obsq[$];
  int          startq[$];

  int m_f;
  int m_pix;
  bit m_closed;
  bit m_err;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: buffer writes, launches and done pulses.
  always @(negedge clk) begin
    if (fm_we) obsq.push_back({fm_addr, fm_wdata});
    if (conv_start) startq.push_back(int'(conv_sel));
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Reference model: one filter's result stream.
  task automatic begin_filter(input int f);
    m_f = f; m_pix = 0; m_closed = 1'b0;
  endtask

  task automatic model_beat(input logic [7:0] d);
    if (m_closed) m_err = 1'b1;
    else if (m_pix < OUT) begin
      expq.push_back({12'(m_f * OUT + m_pix), d});
      m_pix++;
    end else m_err = 1'b1;
  endtask

  task automatic model_done();
    if (!m_closed) begin
      if (m_pix != OUT) m_err = 1'b1;
      m_closed = 1'b1;
    end
  endtask

  task automatic wait_launch(input bit raise_done, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (conv_start) begin
        ok = 1'b1;
        if (raise_done) conv_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("launch_seen", 32'(ok), 32'd1);
  endtask

  task automatic emit(input int nbeats, input int done_beat, input int clear_at, input bit poke);
    logic [7:0] d;
    @(negedge clk);
    for (int k = 0; k < nbeats; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        conv_valid = 1'b0; start = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      d = 8'($urandom);
      conv_valid = 1'b1; conv_data = d;
      start = poke && (k == 3);
      if (k == clear_at) conv_done = 1'b0;
      if (k == done_beat) conv_done = 1'b1;
      model_beat(d);
      if (k == done_beat) model_done();
      @(negedge clk);
      last_cyc = cyc;
      if (k == done_beat) conv_done = 1'b0;
    end
    conv_valid = 1'b0; start = 1'b0;
  endtask

  // mode: 0 no done, 1 done pulse, 2 done held high
  task automatic run_filter(input int f, input int nbeats, input int done_beat, input int mode,
                            input bit raise_in_launch, input int clear_at, input bit poke);
    bit ok;
    wait_launch(raise_in_launch, ok);
    begin_filter(f);
    if (ok) begin
      emit(nbeats, done_beat, clear_at, poke);
      if (mode == 1) begin
        conv_done = 1'b1; model_done();
        @(negedge clk);
        conv_done = 1'b0;
      end else if (mode == 2) begin
        conv_done = 1'b1; model_done();
      end
    end
  endtask

  task automatic start_seq();
    expq.delete(); obsq.delete(); startq.delete();
    m_err = 1'b0;
    done_base = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_clears_flags", {30'd0, err_count, err_timeout}, 32'd0);
  endtask

  task automatic compare_writes();
    int n;
    check("write_count", obsq.size(), expq.size());
    n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
    for (int i = 0; i < n; i++) check("write_addr_data", 32'(obsq[i]), 32'(expq[i]));
  endtask

  task automatic finish_seq(input int n_launch, input bit exp_tmo);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (8) @(negedge clk);
    check("done_count", 32'(done_cnt - done_base), 32'd1);
    check("err_count", 32'(err_count), 32'(m_err));
    check("err_timeout", 32'(err_timeout), 32'(exp_tmo));
    check("launch_count", startq.size(), 32'(n_launch));
    for (int i = 0; i < startq.size(); i++) check("launch_select", 32'(startq[i]), 32'(i));
    compare_writes();
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    conv_valid = 1'b0; conv_data = 8'd0; conv_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_conv_start", 32'(conv_start), 32'd0);
    check("rst_fm_we", 32'(fm_we), 32'd0);
    check("rst_fm_addr", 32'(fm_addr), 32'd0);
    check("rst_select", 32'(conv_sel), 32'd0);
    check("rst_err_flags", {30'd0, err_count, err_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal: all four kernels, full streams.
    start_seq();
    for (int f = 0; f < NF; f++) run_filter(f, OUT, -1, 1, 1'b0, -1, 1'b0);
    finish_seq(NF, 1'b0);

    // Short filter 1; stray start while busy during filter 2.
    start_seq();
    run_filter(0, OUT, -1, 1, 1'b0, -1, 1'b0);
    run_filter(1, OUT - 1, -1, 1, 1'b0, -1, 1'b0);
    run_filter(2, OUT, -1, 1, 1'b0, -1, 1'b1);
    run_filter(3, OUT, -1, 1, 1'b0, -1, 1'b0);
    finish_seq(NF, 1'b0);

    // Overrun with the 676th beat on the done edge.
    start_seq();
    run_filter(0, OUT + 1, OUT - 1, 0, 1'b0, -1, 1'b0);
    for (int f = 1; f < NF; f++) run_filter(f, OUT, -1, 1, 1'b0, -1, 1'b0);
    finish_seq(NF, 1'b0);

    // Stale done level held across the launch, and a done edge inside LAUNCH.
    start_seq();
    run_filter(0, OUT, -1, 2, 1'b0, -1, 1'b0);
    run_filter(1, OUT, -1, 1, 1'b0, 10, 1'b0);
    run_filter(2, OUT, -1, 1, 1'b1, 5, 1'b0);
    run_filter(3, OUT, -1, 1, 1'b0, -1, 1'b0);
    finish_seq(NF, 1'b0);

    // Stall in filter 2: watchdog.
    start_seq();
    run_filter(0, OUT, -1, 1, 1'b0, -1, 1'b0);
    run_filter(1, OUT, -1, 1, 1'b0, -1, 1'b0);
    run_filter(2, 100, -1, 0, 1'b0, -1, 1'b0);
    for (int i = 0; i < TMO + 100; i++) begin
      if (err_timeout) break;
      @(negedge clk);
    end
    check("timeout_latency", 32'(cyc - last_cyc), 32'(TMO));
    check("timeout_done", 32'(done), 32'd1);
    finish_seq(3, 1'b1);

    // Abort mid-filter 1 with a beat in the abort cycle.
    start_seq();
    run_filter(0, OUT - 1, -1, 1, 1'b0, -1, 1'b0);
    run_filter(1, 200, -1, 0, 1'b0, -1, 1'b0);
    d = 8'($urandom);
    conv_valid = 1'b1; conv_data = d; abort = 1'b1;
    model_beat(d);
    @(negedge clk);
    conv_valid = 1'b0; abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_flag_kept", 32'(err_count), 32'd1);
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    check("abort_no_launch", startq.size(), 32'd2);
    compare_writes();

    // start together with abort from IDLE is ignored.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_abort_start_busy", 32'(busy), 32'd0);
    check("idle_abort_start_launch", startq.size(), 32'd2);

    // Restart from filter 0 with flags cleared.
    start_seq();
    for (int f = 0; f < NF; f++) run_filter(f, OUT, -1, 1, 1'b0, -1, 1'b0);
    finish_seq(NF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_filter_scheduler.md
Name: conv_filter_scheduler

Overview:
Sequences the 3x3 convolution engine (conv_layer) over all kernels for one 28x28 image. On one start request it launches the engine once per filter index, 0 to NUM_FILTERS-1. It collects each 26x26 result stream into a flat feature-map buffer with a per-filter base address. It reports completion, per-run pixel-count errors and stalled-engine timeouts.

Parameters:
NUM_FILTERS, 4, number of kernels to run; filter_select width is 2 bits.
OUT_PIXELS, 676, expected valid_out beats per filter (26*26).
GAP_CYCLES, 5, idle cycles between one filter's done and the next launch.
FM_ADDR_W, 12, feature-map address width; must cover NUM_FILTERS*OUT_PIXELS.
TIMEOUT, 4095, max consecutive RUN cycles with neither valid nor done.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to process all filters; ignored unless IDLE.
abort  in  1  synchronous abort; returns to IDLE next cycle.
conv_start  out  1  one-cycle launch pulse to the engine.
conv_filter_select  out  2  kernel index for the engine.
conv_valid  in  1  engine valid_out.
conv_data  in  8  engine data_out.
conv_done  in  1  engine done; level or pulse; rising edge is used.
fm_we  out  1  feature-map write enable.
fm_addr  out  FM_ADDR_W  feature-map write address.
fm_wdata  out  8  feature-map write data.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the sequence ends (normal, error or timeout).
err_count  out  1  sticky: some filter produced a count other than OUT_PIXELS; cleared on accepted start.
err_timeout  out  1  sticky: watchdog fired; cleared on accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, filter_idx 0, pix_cnt 0, gap_cnt 0, wdog 0, done_q 0.
- done_q is registered conv_done; done_rise = conv_done & ~done_q.
- IDLE: on start, clear err_count, err_timeout and filter_idx, then go to LAUNCH.
- LAUNCH (1 cycle):
  - conv_start = 1; conv_filter_select = filter_idx, registered and held stable until the next LAUNCH.
  - pix_cnt = 0, wdog = 0; go to RUN.
- RUN:
  - Each conv_valid cycle: if pix_cnt < OUT_PIXELS, next cycle fm_we = 1, fm_addr = filter_idx*OUT_PIXELS + pix_cnt, fm_wdata = conv_data; pix_cnt += 1.
  - Write latency is exactly 1 cycle. fm_we is 0 otherwise.
  - If pix_cnt already equals OUT_PIXELS, the beat is dropped (no write) and err_count is set.
  - On done_rise: set err_count if pix_cnt != OUT_PIXELS; go to GAP with gap_cnt = 0.
  - If valid and done_rise occur in the same cycle, the beat is written and counted first, and the count check uses the incremented value.
  - wdog counts RUN cycles and resets on conv_valid or done_rise. When wdog reaches TIMEOUT, set err_timeout and go to FINISH.
  - done_rise seen in LAUNCH (a stale level from the previous run) is ignored; done_q still updates.
- GAP:
  - gap_cnt increments each cycle. After GAP_CYCLES cycles:
  - if filter_idx == NUM_FILTERS-1, go to FINISH;
  - else filter_idx += 1 and go to LAUNCH.
  - conv_valid in GAP is dropped and sets err_count.
- FINISH (1 cycle): done = 1, then IDLE. busy falls in the cycle after done.
- abort in any non-IDLE state:
  - next state IDLE, with no done pulse and no conv_start.
  - A pending fm_we for a beat captured in the abort cycle still issues.
  - Error flags are kept.
  - abort takes priority over all other transitions. start in the same cycle as abort (from IDLE) is ignored.
- Arithmetic: base address uses a multiply-free accumulator; base += OUT_PIXELS on each filter advance. Max address is NUM_FILTERS*OUT_PIXELS-1 = 2703.

Test Plan:
- Nominal: start; engine model emits 676 valids then done per filter. Required: conv_start pulses with select 0, 1, 2, 3; 2704 writes to addresses 0..2703 in order; done pulses once; no error flags.
- Short run: filter 1 emits 675 valids then done. Required: err_count = 1; filter 2 writes still start at address 1352; done still pulses.
- Overrun plus simultaneous event: filter 0 emits 677 valids, and the 676th valid coincides with the done rise. Required: the 676th beat is written; the 677th beat is dropped (no fm_we) and sets err_count.
- Stall: filter 2 stops after 100 valids with no done. Required: err_timeout rises TIMEOUT cycles after the last valid; done pulses; no filter 3 launch.
- Stale level done: engine holds done high after filter 0. Required: no spurious advance; filter 1 runs normally after a fresh done edge.
- Abort/busy: start during busy is ignored. Abort mid-filter 1 leads to IDLE the next cycle, with no done and busy = 0. A new start then restarts from filter 0 with flags cleared.
